// File: rtl/ifetch_if.sv
// Instruction-memory fetch port between the fetch stage and imem.
// The fetch stage drives address/request; memory answers with data/ready.
interface ifetch_if;
   logic [31:0] ImemAddrF;
   logic        ImemReqF;
   logic [31:0] ImemRdataF;
   logic        ImemReadyF;

   modport master (
      output ImemAddrF,
      output ImemReqF,
      input  ImemRdataF,
      input  ImemReadyF
   );

   modport slave (
      input  ImemAddrF,
      input  ImemReqF,
      output ImemRdataF,
      output ImemReadyF
   );
endinterface

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, the imem request and the IF/ID register.
// Memory waits are retried in place; redirects from execute always win.
module ifetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   ifetch_if.master    imem,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        MisalignF
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcPlus4;
   } ifIdT;

   logic [31:0] pcPlus4F;
   logic [31:0] redirectPc;
   logic [31:0] pcNext;
   logic        memWait;
   logic        misTarget;
   ifIdT        ifId;
   ifIdT        ifIdNext;

   assign pcPlus4F   = PCF + 32'd4;
   assign redirectPc = {PCTargetE[31:2], 2'b00};
   assign memWait    = ~imem.ImemReadyF;
   assign misTarget  = PCSrcE & (|PCTargetE[1:0]);

   assign imem.ImemAddrF = PCF;
   assign imem.ImemReqF  = ~StallF;

   always_comb begin
      pcNext = pcPlus4F;
      priority case (1'b1)
         PCSrcE:             pcNext = redirectPc;
         (StallF | memWait): pcNext = PCF;
         default:            pcNext = pcPlus4F;
      endcase
   end

   // A waiting fetch still records its PC so the bubble is traceable.
   always_comb begin
      ifIdNext = ifId;
      priority case (1'b1)
         FlushD: begin
            ifIdNext.instr   = NOP_INSTR;
            ifIdNext.pc      = 32'd0;
            ifIdNext.pcPlus4 = 32'd0;
         end
         StallD: ifIdNext = ifId;
         memWait: begin
            ifIdNext.instr   = NOP_INSTR;
            ifIdNext.pc      = PCF;
            ifIdNext.pcPlus4 = pcPlus4F;
         end
         default: begin
            ifIdNext.instr   = imem.ImemRdataF;
            ifIdNext.pc      = PCF;
            ifIdNext.pcPlus4 = pcPlus4F;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PCF <= RESET_PC;
      end else begin
         PCF <= pcNext;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifId.instr   <= NOP_INSTR;
         ifId.pc      <= 32'd0;
         ifId.pcPlus4 <= 32'd0;
      end else begin
         ifId <= ifIdNext;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         MisalignF <= 1'b0;
      end else if (misTarget) begin
         MisalignF <= 1'b1;
      end
   end

   assign InstrD   = ifId.instr;
   assign PCD      = ifId.pc;
   assign PCPlus4D = ifId.pcPlus4;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios with literal
// expectations, then random stimulus against a behavioural model.
module tb_ifetch;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        PCSrcE = 1'b0;
   logic [31:0] PCTargetE = 32'd0;
   logic        StallF = 1'b0;
   logic        StallD = 1'b0;
   logic        FlushD = 1'b0;
   logic        ready = 1'b1;
   logic [31:0] PCF, InstrD, PCD, PCPlus4D;
   logic        MisalignF;

   int nChecks = 0;
   int nPass = 0;

   ifetch_if imem ();

   // Memory image: word at address A is 0x1000_0000 | A; garbage while not ready.
   assign imem.ImemReadyF = ready;
   assign imem.ImemRdataF = ready ? (32'h1000_0000 | imem.ImemAddrF)
                                  : 32'hDEAD_BEEF;

   ifetch dut (
      .clk       (clk),
      .reset     (reset),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .imem      (imem),
      .PCF       (PCF),
      .InstrD    (InstrD),
      .PCD       (PCD),
      .PCPlus4D  (PCPlus4D),
      .MisalignF (MisalignF)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: what fetch/decode must see, from the stage rules.
   logic [31:0] mPC, mInstr, mPCD, mPC4D;
   logic        mMis;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mPC = 32'd0; mInstr = NOP; mPCD = 32'd0; mPC4D = 32'd0; mMis = 1'b0;
      end else begin
         if (FlushD) begin
            mInstr = NOP; mPCD = 0; mPC4D = 0;
         end else if (!StallD) begin
            mInstr = ready ? (32'h1000_0000 | mPC) : NOP;
            mPCD   = mPC;
            mPC4D  = mPC + 4;
         end
         if (PCSrcE) begin
            mPC = PCTargetE & 32'hFFFF_FFFC;
            if (PCTargetE % 4 != 0) mMis = 1'b1;
         end else if (!StallF && ready) begin
            mPC = mPC + 4;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("PCF", PCF, mPC);
         check("ImemAddrF", imem.ImemAddrF, mPC);
         check("ImemReqF", {31'd0, imem.ImemReqF}, {31'd0, ~StallF});
         check("InstrD", InstrD, mInstr);
         check("PCD", PCD, mPCD);
         check("PCPlus4D", PCPlus4D, mPC4D);
         check("MisalignF", {31'd0, MisalignF}, {31'd0, mMis});
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic src, input logic [31:0] tgt,
                        input logic sf, input logic sd, input logic fd,
                        input logic rdy);
      PCSrcE = src; PCTargetE = tgt; StallF = sf; StallD = sd;
      FlushD = fd; ready = rdy;
   endtask

   task automatic expD(input string tag, input logic [31:0] pc,
                       input logic [31:0] ins, input logic [31:0] pcd,
                       input logic [31:0] pc4d);
      check({tag, ".PCF"}, PCF, pc);
      check({tag, ".InstrD"}, InstrD, ins);
      check({tag, ".PCD"}, PCD, pcd);
      check({tag, ".PCPlus4D"}, PCPlus4D, pc4d);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      expD("rst", 32'h0, NOP, 32'h0, 32'h0);
      check("rst.Addr", imem.ImemAddrF, 32'h0);
      check("rst.Mis", {31'd0, MisalignF}, 32'd0);
      reset = 1'b0;

      cyc(); expD("seq1", 32'h4, 32'h1000_0000, 32'h0, 32'h4);
      cyc(); expD("seq2", 32'h8, 32'h1000_0004, 32'h4, 32'h8);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(); expD("wait", 32'h8, NOP, 32'h8, 32'hC);
      end
      drive(0, 0, 0, 0, 0, 1);
      cyc(); expD("wdone", 32'hC, 32'h1000_0008, 32'h8, 32'hC);
      cyc(); expD("seq4", 32'h10, 32'h1000_000C, 32'hC, 32'h10);

      drive(1, 32'h40, 0, 0, 1, 1);
      cyc(); expD("br1", 32'h40, NOP, 32'h0, 32'h0);
      drive(0, 0, 0, 0, 0, 1);
      cyc(); expD("br2", 32'h44, 32'h1000_0040, 32'h40, 32'h44);

      drive(1, 32'h10, 0, 0, 1, 1);
      cyc(); expD("br3", 32'h10, NOP, 32'h0, 32'h0);
      drive(0, 0, 0, 0, 0, 1);
      cyc(); expD("pre", 32'h14, 32'h1000_0010, 32'h10, 32'h14);
      drive(0, 0, 1, 1, 0, 1);
      cyc(); expD("luse", 32'h14, 32'h1000_0010, 32'h10, 32'h14);
      drive(0, 0, 0, 0, 0, 1);
      cyc(); expD("resume", 32'h18, 32'h1000_0014, 32'h14, 32'h18);

      drive(1, 32'h103, 1, 0, 0, 0);
      cyc(); expD("mis", 32'h100, NOP, 32'h18, 32'h1C);
      check("mis.flag", {31'd0, MisalignF}, 32'd1);
      drive(0, 0, 0, 0, 0, 1);
      cyc(); expD("mis2", 32'h104, 32'h1000_0100, 32'h100, 32'h104);
      check("mis.sticky", {31'd0, MisalignF}, 32'd1);

      drive(1, 32'hFFFF_FFFC, 0, 1, 1, 1);
      cyc(); expD("flst", 32'hFFFF_FFFC, NOP, 32'h0, 32'h0);
      drive(0, 0, 0, 0, 0, 1);
      cyc(); expD("wrap", 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);

      drive(1, 32'h24, 0, 0, 1, 1);
      cyc(); check("pre24", PCF, 32'h24);
      drive(0, 0, 0, 0, 0, 0);
      cyc(); expD("w24", 32'h24, NOP, 32'h24, 32'h28);
      #2 reset = 1'b1;
      #1;
      expD("arst", 32'h0, NOP, 32'h0, 32'h0);
      check("arst.Mis", {31'd0, MisalignF}, 32'd0);
      cyc();
      reset = 1'b0;
      ready = 1'b1;
      cyc(); expD("restart", 32'h4, 32'h1000_0000, 32'h0, 32'h4);

      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 75) begin
            reset = 1'b1;
            cyc();
            reset = 1'b0;
         end
         PCSrcE    = ($urandom_range(0, 7) == 0);
         PCTargetE = {$urandom_range(0, 255), 2'b00}
                     | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
         StallF    = ($urandom_range(0, 5) == 0);
         StallD    = StallF ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
         FlushD    = PCSrcE ? 1'b1 : ($urandom_range(0, 9) == 0);
         ready     = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
